// File: rtl/iou_multi_tc_pkg.sv
// Shared definitions for the multi-timer I/O unit: register offsets, CTRL bit
// positions, the base-address compare range and the per-channel register decode.
package iou_multi_tc_pkg;

  localparam logic [31:0] CONST_NEG1 = 32'hFFFF_FFFF;

  // Address bits compared against the unit base (upper 24 bits of the byte address)
  localparam int SEL_MSB = 31;
  localparam int SEL_LSB = 8;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [7:0] OFF_PEND   = 8'h40;
  localparam logic [7:0] OFF_MASK   = 8'h44;
  localparam logic [7:0] OFF_LED    = 8'h48;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PSC    = 8;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_PRESET,
    REG_COUNT,
    REG_NONE
  } chan_reg_e;

  function automatic chan_reg_e chan_reg(input logic [3:0] lo);
    case (lo)
      OFF_CTRL:   return REG_CTRL;
      OFF_PRESET: return REG_PRESET;
      OFF_COUNT:  return REG_COUNT;
      default:    return REG_NONE;
    endcase
  endfunction

  function automatic logic io_select(input logic [23:0] addr_hi, input logic [23:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/iou_multi_tc_if.sv
// Data-memory side bus of the I/O unit. Vectors keep the big-endian numbering
// of the core bus: bit 0 is the MSB, BE[0] covers din[0:7].
interface iou_multi_tc_if;
  logic [0:31] addr;
  logic        wr;
  logic [0:3]  BE;
  logic [0:31] din;
  logic [0:31] dout;

  modport master (output addr, wr, BE, din, input dout);
  modport slave  (input addr, wr, BE, din, output dout);
endinterface

// File: rtl/iou_multi_tc_chan.sv
// One down-counting timer channel: CTRL/PRESET/COUNT and the fire pulse.
// Optional per-channel prescaler under IOU_PRESCALE_EN.
module iou_multi_tc_chan
  import iou_multi_tc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_we,
  input  logic        preset_we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        fire
);

  logic        en, reload, ie, tick;
  logic [31:0] preset_nxt;

  always_comb begin
    preset_nxt = preset;
    for (int k = 0; k < 4; k++)
      if (be[k]) preset_nxt[8*k +: 8] = wdata[8*k +: 8];
  end

`ifdef IOU_PRESCALE_EN
  logic [7:0] psc, psc_cnt;

  assign tick = (psc_cnt == psc);

  always_comb begin
    ctrl = '0;
    ctrl[CTRL_EN]            = en;
    ctrl[CTRL_RELOAD]        = reload;
    ctrl[CTRL_IE]            = ie;
    ctrl[CTRL_PSC +: 8]      = psc;
  end

  // Prescaler restarts whenever the channel is re-armed or stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else begin
      if (ctrl_we && be[1]) psc <= wdata[CTRL_PSC +: 8];
      if (preset_we || !en) psc_cnt <= '0;
      else                  psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;

  always_comb begin
    ctrl = '0;
    ctrl[CTRL_EN]     = en;
    ctrl[CTRL_RELOAD] = reload;
    ctrl[CTRL_IE]     = ie;
  end
`endif

  assign fire = !preset_we && en && tick && ie && (count == 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en     <= 1'b0;
      reload <= 1'b0;
      ie     <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      if (ctrl_we && be[0]) begin
        en     <= wdata[CTRL_EN];
        reload <= wdata[CTRL_RELOAD];
        ie     <= wdata[CTRL_IE];
      end
      if (preset_we) begin
        preset <= preset_nxt;
        count  <= preset_nxt;
      end else if (en && tick) begin
        if (count > 32'd1)                 count <= count - 32'd1;
        else if (count == 32'd1)           count <= '0;
        else if (reload && preset != '0)   count <= preset;
      end
    end
  end

endmodule

// File: rtl/iou_multi_tc.sv
// Multi-timer memory-mapped I/O unit: address decode, PEND/MASK interrupt
// aggregation, LED register and read mux. Optional prescaler: IOU_PRESCALE_EN.
module iou_multi_tc
  import iou_multi_tc_pkg::*;
#(
  parameter int          NUM_TC  = 2,
  parameter int          LED_W   = 8,
  parameter logic [31:0] IO_BASE = 32'h0000_7F00
) (
  input  logic             clk,
  input  logic             rst_n,
  iou_multi_tc_if.slave    bus,
  output logic [LED_W-1:0] LED_dis,
  output logic             hw_int
);

  logic [31:0]       addr, din, rdata;
  logic [3:0]        be;
  logic [7:0]        off;
  logic              sel, wr_sel;
  chan_reg_e         creg;
  logic [NUM_TC-1:0] fire, pend, mask, pend_clr;
  logic [LED_W-1:0]  led;
  logic [31:0]       ch_ctrl   [NUM_TC];
  logic [31:0]       ch_preset [NUM_TC];
  logic [31:0]       ch_count  [NUM_TC];

  // Re-index the big-endian bus into value order: be[k] covers din[8k+7:8k]
  assign addr     = bus.addr;
  assign din      = bus.din;
  assign be       = bus.BE;
  assign bus.dout = rdata;

  assign sel    = io_select(addr[SEL_MSB:SEL_LSB], IO_BASE[SEL_MSB:SEL_LSB]);
  assign off    = addr[7:0];
  assign wr_sel = bus.wr && sel;
  assign creg   = chan_reg(off[3:0]);

  for (genvar n = 0; n < NUM_TC; n++) begin : g_ch
    logic this_ch;
    assign this_ch = wr_sel && (off[7:4] == 4'(n));

    iou_multi_tc_chan u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctrl_we   (this_ch && (creg == REG_CTRL)),
      .preset_we (this_ch && (creg == REG_PRESET)),
      .be        (be),
      .wdata     (din),
      .ctrl      (ch_ctrl[n]),
      .preset    (ch_preset[n]),
      .count     (ch_count[n]),
      .fire      (fire[n])
    );
  end

  assign pend_clr = (wr_sel && off == OFF_PEND && be[0]) ? din[NUM_TC-1:0] : '0;

  // A fire in the same cycle as a clear of that bit leaves it pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      mask <= '0;
      led  <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | fire;
      if (wr_sel && off == OFF_MASK && be[0]) mask <= din[NUM_TC-1:0];
      if (wr_sel && off == OFF_LED)
        for (int i = 0; i < LED_W; i++)
          if (be[i/8]) led[i] <= din[i];
    end
  end

  assign hw_int  = |(pend & mask);
  assign LED_dis = led;

  always_comb begin
    rdata = CONST_NEG1;
    if (sel) begin
      if (off == OFF_PEND)      rdata = 32'(pend);
      else if (off == OFF_MASK) rdata = 32'(mask);
      else if (off == OFF_LED)  rdata = 32'(led);
      else begin
        for (int n = 0; n < NUM_TC; n++) begin
          if (off[7:4] == 4'(n)) begin
            case (creg)
              REG_CTRL:   rdata = ch_ctrl[n];
              REG_PRESET: rdata = ch_preset[n];
              REG_COUNT:  rdata = ch_count[n];
              default:    rdata = CONST_NEG1;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iou_multi_tc.sv
// Directed scoreboard bench for iou_multi_tc (NUM_TC=2, LED_W=8, base 0x7F00).
module tb_iou_multi_tc;

  localparam logic [31:0] B = 32'h0000_7F00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led_dis;
  logic       hw_int;
  int         checks   = 0;
  int         failures = 0;
  logic [31:0] exp_q[$];

  iou_multi_tc_if bus ();

  iou_multi_tc #(.NUM_TC(2), .LED_W(8), .IO_BASE(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .LED_dis (led_dis),
    .hw_int  (hw_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    chk(tag, obs);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.wr   = 1'b0;
    exp_q.push_back(exp);
    #1;
    chk(tag, bus.dout);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr = a;
    bus.din  = d;
    bus.BE   = be;
    bus.wr   = 1'b1;
    @(negedge clk);
    bus.wr   = 1'b0;
    bus.BE   = 4'b0000;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.addr = '0;
    bus.din  = '0;
    bus.BE   = '0;
    bus.wr   = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd("rst_ctrl0", B + 32'h00, 32'h0);
    rd("rst_pend", B + 32'h40, 32'h0);
    rd("unmapped_4c", B + 32'h4C, 32'hFFFF_FFFF);
    rd("unselected", 32'h0000_8040, 32'hFFFF_FFFF);
    sig("rst_led", 32'(led_dis), 32'h0);
    sig("rst_hw_int", 32'(hw_int), 32'h0);

    wr(B + 32'h48, 32'h0000_00A5, 4'b0001);
    sig("led_a5", 32'(led_dis), 32'hA5);
    wr(B + 32'h48, 32'hFFFF_FF00, 4'b1110);
    sig("led_be_hold", 32'(led_dis), 32'hA5);
    rd("led_read", B + 32'h48, 32'hA5);
    wr(32'h0000_8048, 32'hFFFF_FFFF, 4'b1111);
    sig("led_unsel_wr", 32'(led_dis), 32'hA5);

    wr(B + 32'h44, 32'hFFFF_FFFF, 4'b1111);
    rd("mask_upper_bits", B + 32'h44, 32'h3);

    // Channel 0 one-shot
    wr(B + 32'h44, 32'h1, 4'b0001);
    wr(B + 32'h04, 32'h3, 4'b1111);
    wr(B + 32'h00, 32'h5, 4'b0001);
    rd("os_cnt3", B + 32'h08, 32'd3);
    step();
    rd("os_cnt2", B + 32'h08, 32'd2);
    step();
    rd("os_cnt1", B + 32'h08, 32'd1);
    sig("os_hw_pre", 32'(hw_int), 32'h0);
    step();
    rd("os_cnt0", B + 32'h08, 32'd0);
    rd("os_pend", B + 32'h40, 32'h1);
    sig("os_hw_fire", 32'(hw_int), 32'h1);
    step();
    rd("os_hold0", B + 32'h08, 32'd0);
    wr(B + 32'h40, 32'h1, 4'b0001);
    sig("os_w1c_hw", 32'(hw_int), 32'h0);
    rd("os_w1c_pend", B + 32'h40, 32'h0);
    rd("ctrl0_read", B + 32'h00, 32'h5);

    // Channel 1 auto-reload, period 3
    wr(B + 32'h44, 32'h2, 4'b0001);
    wr(B + 32'h14, 32'h2, 4'b1111);
    wr(B + 32'h10, 32'h7, 4'b0001);
    rd("ar_cnt2", B + 32'h18, 32'd2);
    rd("ar_pend0", B + 32'h40, 32'h0);
    step();
    rd("ar_cnt1", B + 32'h18, 32'd1);
    step();
    rd("ar_cnt0", B + 32'h18, 32'd0);
    rd("ar_pend_fire", B + 32'h40, 32'h2);
    sig("ar_hw_fire", 32'(hw_int), 32'h1);
    wr(B + 32'h40, 32'h2, 4'b0001);
    rd("ar_pend_clr", B + 32'h40, 32'h0);
    sig("ar_hw_clr", 32'(hw_int), 32'h0);
    rd("ar_reload", B + 32'h18, 32'd2);
    step();
    rd("ar_cnt1b", B + 32'h18, 32'd1);
    wr(B + 32'h40, 32'h2, 4'b0001);
    rd("ar_set_wins", B + 32'h40, 32'h2);
    sig("ar_hw_set_wins", 32'(hw_int), 32'h1);
    rd("ar_cnt0b", B + 32'h18, 32'd0);
    step();
    rd("ar_reload2", B + 32'h18, 32'd2);

    // Single-byte PRESET write loads COUNT with the merged value
    wr(B + 32'h04, 32'h1234_5678, 4'b0001);
    rd("preset_byte", B + 32'h04, 32'h78);
    rd("count_load", B + 32'h08, 32'h78);
    step();
    rd("count_dec", B + 32'h08, 32'h77);

    // Asynchronous reset mid-count
    wr(B + 32'h04, 32'h8, 4'b1111);
    repeat (3) step();
    rd("pre_rst_cnt5", B + 32'h08, 32'd5);
    sig("pre_rst_hw", 32'(hw_int), 32'h1);
    rst_n = 1'b0;
    rd("rst_async_cnt", B + 32'h08, 32'd0);
    rd("rst_async_pend", B + 32'h40, 32'h0);
    sig("rst_async_hw", 32'(hw_int), 32'h0);
    sig("rst_async_led", 32'(led_dis), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef IOU_PRESCALE_EN
    wr(B + 32'h44, 32'h1, 4'b0001);
    wr(B + 32'h04, 32'h2, 4'b1111);
    wr(B + 32'h00, 32'h0000_0105, 4'b0011);
    rd("psc_ctrl", B + 32'h00, 32'h0000_0105);
    rd("psc_c0", B + 32'h08, 32'd2);
    step();
    rd("psc_c1", B + 32'h08, 32'd2);
    step();
    rd("psc_c2", B + 32'h08, 32'd1);
    step();
    rd("psc_c3", B + 32'h08, 32'd1);
    sig("psc_hw_pre", 32'(hw_int), 32'h0);
    step();
    rd("psc_c4", B + 32'h08, 32'd0);
    sig("psc_hw_fire", 32'(hw_int), 32'h1);
`else
    wr(B + 32'h00, 32'h0000_FF05, 4'b0011);
    rd("psc_absent", B + 32'h00, 32'h5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
